// File: rtl/aes_cipher_iter_pkg.sv
// Shared AES definitions: block size, FSM states, S-box, GF helpers and key schedule.
package aes_cipher_iter_pkg;

    localparam int unsigned AES_BLK   = 128;
    localparam int unsigned MAX_WORDS = 60;

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_e;
    typedef logic [31:0] word_t;
    typedef word_t key_sched_t [MAX_WORDS];

    localparam logic [2047:0] SBOX = {
        256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
        256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
        256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
        256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
        256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
        256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
        256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
        256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic nk_nr_legal(input int unsigned nk, input int unsigned nr);
        return (nk == 4 && nr == 10) || (nk == 6 && nr == 12) || (nk == 8 && nr == 14);
    endfunction

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX[8*(255 - 32'(b)) +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic word_t sub_word(input word_t w);
        return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
    endfunction

    // key is left-aligned in 256 bits; words past 4*(nr+1) stay zero
    function automatic key_sched_t key_expand(input logic [255:0] key, input int unsigned nk,
                                              input int unsigned nr);
        key_sched_t w;
        word_t      t;
        logic [7:0] rc;
        rc = 8'h01;
        for (int unsigned i = 0; i < MAX_WORDS; i++) begin
            w[i] = '0;
            if (i < nk) begin
                w[i] = key[255 - 32*(i % 8) -: 32];
            end else if (i < 4*(nr + 1)) begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = xtime(rc);
                end else if (nk > 6 && i % nk == 4) begin
                    t = sub_word(t);
                end
                w[i] = w[i-nk] ^ t;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/aes_cipher_iter_if.sv
// Plaintext-in / ciphertext-out handshake bundle for aes_cipher_iter.
interface aes_cipher_iter_if
    import aes_cipher_iter_pkg::*;
#(
    parameter int unsigned NK = 4
);
    logic               i_valid;
    logic               o_ready;
    logic [AES_BLK-1:0] i_data;
    logic [32*NK-1:0]   i_key;
    logic               o_valid;
    logic               i_ready;
    logic [AES_BLK-1:0] o_data;

    modport master (output i_valid, i_data, i_key, i_ready, input o_ready, o_valid, o_data);
    modport slave  (input i_valid, i_data, i_key, i_ready, output o_ready, o_valid, o_data);
endinterface

// File: rtl/aes_cipher_iter_enc_round.sv
// One combinational AES forward round: SubBytes, ShiftRows, MixColumns (skipped when last), AddRoundKey.
module aes_cipher_iter_enc_round
    import aes_cipher_iter_pkg::*;
(
    input  logic [AES_BLK-1:0] blk,
    input  logic [AES_BLK-1:0] rk,
    input  logic               last,
    output logic [AES_BLK-1:0] result
);
    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];

    // byte i sits at [127-8i]; column c holds bytes 4c..4c+3
    always_comb begin
        sb     = '{default: '0};
        sr     = '{default: '0};
        mc     = '{default: '0};
        result = '0;
        for (int unsigned i = 0; i < 16; i++) sb[i] = sub_byte(blk[127 - 8*i -: 8]);
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) sr[4*c + r] = sb[4*((c + r) % 4) + r];
        end
        for (int unsigned c = 0; c < 4; c++) begin
            mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
            mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
        end
        for (int unsigned i = 0; i < 16; i++) begin
            result[127 - 8*i -: 8] = (last ? sr[i] : mc[i]) ^ rk[127 - 8*i -: 8];
        end
    end
endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES-128/192/256 encryptor: one round per clock through a shared round datapath.
module aes_cipher_iter
    import aes_cipher_iter_pkg::*;
#(
    parameter int unsigned NK = 4,
    parameter int unsigned NR = 10
) (
    input  logic          i_clk,
    input  logic          i_rst,
    aes_cipher_iter_if.slave io
);
    localparam int unsigned CW = $clog2(NR + 1);

    if (!nk_nr_legal(NK, NR)) begin : g_illegal_params
        $error("aes_cipher_iter: illegal NK/NR pair");
    end

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q;
    logic [AES_BLK-1:0] st_q, st_nxt, rk_cur;
    logic [32*NK-1:0]   key_q;
    logic [255:0]       key_full;
    key_sched_t         w;
    logic               last;
    logic               accept;

    assign last   = (cnt_q == CW'(NR));
    assign accept = io.i_valid && io.o_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept)     state_d = S_ROUND;
            S_ROUND: if (last)       state_d = S_DONE;
            S_DONE:  if (io.i_ready) state_d = S_IDLE;
            default:                 state_d = S_IDLE;
        endcase
    end

    always_comb begin
        io.o_ready = (state_q == S_IDLE);
        io.o_valid = (state_q == S_DONE);
    end

    assign io.o_data = st_q;

    // schedule is derived from the latched key only, so inputs may change after accept
    always_comb begin
        key_full                = '0;
        key_full[255 -: 32*NK]  = key_q;
        w                       = key_expand(key_full, NK, NR);
        rk_cur                  = '0;
        for (int unsigned k = 0; k < 4; k++) rk_cur[127 - 32*k -: 32] = w[4*32'(cnt_q) + k];
    end

    aes_cipher_iter_enc_round u_round (
        .blk    (st_q),
        .rk     (rk_cur),
        .last   (last),
        .result (st_nxt)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
            st_q  <= '0;
            key_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    key_q <= io.i_key;
                    st_q  <= io.i_data ^ io.i_key[32*NK-1 -: AES_BLK];
                    cnt_q <= CW'(1);
                end
                S_ROUND: begin
                    st_q  <= st_nxt;
                    cnt_q <= last ? '0 : cnt_q + CW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule
